// File: rtl/seq_alu_mdu.sv
// Execute unit: ALU/shift ops plus iterative unsigned MUL/MULHU/DIVU/REMU.
// Latency: 1 cycle after accept for ALU ops, WIDTH+1 cycles for MDU ops.
// Backpressure: result is held in DONE until out_ready; no accept while busy or done.
module seq_alu_mdu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_UND0 = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_UND1 = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;     // multiplier then product low half / quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor
    logic [1:0]       mop_q, mop_d;   // bit1: divide, bit0: select high register
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Adder shared by ADD/SUB/SLT/SLTU; MSB handled separately to expose its carry-in
    logic             sub_op, flag_op, c_msb_in, c_out, slt_lt;
    logic [WIDTH-1:0] b_eff, low_add, sum;
    logic [SHW-1:0]   shamt;

    assign sub_op   = (ctrl == OP_SUB) || (ctrl == OP_SLT) || (ctrl == OP_SLTU);
    assign flag_op  = sub_op || (ctrl == OP_ADD);
    assign b_eff    = sub_op ? ~op_b : op_b;
    assign low_add  = {1'b0, op_a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                    + {{(WIDTH-1){1'b0}}, sub_op};
    assign c_msb_in = low_add[WIDTH-1];
    assign sum      = {op_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ c_msb_in, low_add[WIDTH-2:0]};
    assign c_out    = (op_a[WIDTH-1] & b_eff[WIDTH-1]) | (op_a[WIDTH-1] & c_msb_in)
                    | (b_eff[WIDTH-1] & c_msb_in);
    // Differing signs decide directly; equal signs cannot overflow so the difference sign decides
    assign slt_lt   = (op_a[WIDTH-1] != op_b[WIDTH-1]) ? op_a[WIDTH-1] : sum[WIDTH-1];
    assign shamt    = op_b[SHW-1:0];

    logic [WIDTH-1:0] alu_res;
    // Single-cycle ALU/shift result; undefined codes yield zero
    always_comb begin
        alu_res = '0;
        case (ctrl)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = sum;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~c_out};
            OP_SUB:  alu_res = sum;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide
    logic [WIDTH:0]   mul_sum, div_rem, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_step, lo_step;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign div_rem  = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = div_rem >= {1'b0, opb_q};
    assign div_diff = div_rem - {1'b0, opb_q};

    // Select the step flavour; a zero divisor naturally gives all-ones quotient and remainder = A
    always_comb begin
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (mop_q[1]) begin
            hi_step = div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    // Next-state logic for the IDLE/BUSY/DONE sequencer and datapath registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        mop_d   = mop_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (ctrl[3:2] == 2'b11) begin
                        hi_d    = '0;
                        lo_d    = op_a;
                        opb_d   = op_b;
                        mop_d   = ctrl[1:0];
                        cnt_d   = CNT_INIT;
                        state_d = S_BUSY;
                    end else begin
                        res_d   = alu_res;
                        carry_d = flag_op & c_out;
                        ovf_d   = flag_op & (c_msb_in ^ c_out);
                        zero_d  = (ctrl != OP_UND0) && (ctrl != OP_UND1) && (alu_res == '0);
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    res_d   = mop_q[0] ? hi_step : lo_step;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = ((mop_q[0] ? hi_step : lo_step) == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            mop_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            mop_q   <= mop_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_seq_alu_mdu.sv
// Scoreboard bench for seq_alu_mdu: directed vectors with hand-computed results.
// Latency: checks 1-cycle ALU and 33-cycle MDU result timing.
// Backpressure: holds out_ready low in DONE and checks the result stays put.
module tb_seq_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [3:0]   ctrl = 4'b0000;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] res;
    logic         carry, overflow, zero;

    seq_alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .ctrl(ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .carry(carry), .overflow(overflow),
        .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: on each new result, pop the expected entry and compare
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got res 0x%0h with empty scoreboard", res);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_res"}, 64'(res), 64'(e.res));
                check({e.name, "_carry"}, 64'(carry), 64'(e.c));
                check({e.name, "_ovf"}, 64'(overflow), 64'(e.o));
                check({e.name, "_zero"}, 64'(zero), 64'(e.z));
                check({e.name, "_lat"}, 64'(cyc - accept_cyc), 64'(e.lat));
            end
        end
        prev_ov = out_valid;
    end

    // Issue one op from a negedge; optionally scramble inputs after accept and hold the result
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ec,
                          input logic eo, input logic ez, input int elat,
                          input bit scramble, input int hold);
        exp_t e;
        int   k;
        bit   busy_ok;
        logic [34:0] snap;
        e.name = name; e.res = er; e.c = ec; e.o = eo; e.z = ez; e.lat = elat;
        sb.push_back(e);
        ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        check({name, "_accept"}, 64'(in_ready), 64'd1);
        accept_cyc = cyc;
        @(negedge clk);
        if (scramble) begin
            op_a = ~a; op_b = ~b; ctrl = 4'b0010;
        end else begin
            in_valid = 1'b0;
        end
        k = 0;
        busy_ok = 1'b1;
        while (!out_valid && k < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check({name, "_done"}, 64'(out_valid), 64'd1);
        if (elat > 1) check({name, "_in_ready_busy"}, 64'(busy_ok), 64'd1);
        if (hold > 0) begin
            snap = {res, carry, overflow, zero};
            repeat (hold) begin
                @(negedge clk);
                check({name, "_bp_hold"}, {27'd0, res, carry, overflow, zero, out_valid, in_ready},
                      {27'd0, snap, 1'b1, 1'b0});
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({name, "_handoff"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_outputs", {29'd0, out_valid, res, carry, overflow, zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1, 0, 0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1, 0, 1, 1, 0, 0);
        run_op("slt",      4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0, 0, 1, 0, 0);
        run_op("sltu",     4'b0101, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 1, 1, 0, 0);
        run_op("sra",      4'b1011, 32'h80000000, 32'd4, 32'hF8000000, 0, 0, 0, 1, 0, 0);
        run_op("srl",      4'b1001, 32'h80000000, 32'd4, 32'h08000000, 0, 0, 0, 1, 0, 0);
        run_op("sll_mask", 4'b1000, 32'd1, 32'h21, 32'h00000002, 0, 0, 0, 1, 0, 0);
        run_op("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1, 0, 0);
        run_op("or",       4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 1, 0, 0);
        run_op("xor",      4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 1, 0, 0);
        run_op("undef",    4'b0100, 32'd5, 32'd3, 32'd0, 0, 0, 0, 1, 0, 0);
        run_op("mul",      4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 33, 1, 0);
        run_op("mulhu",    4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 33, 0, 0);
        run_op("mul_zlo",  4'b1100, 32'h00010000, 32'h00010000, 32'h00000000, 0, 0, 1, 33, 0, 0);
        run_op("mulhu_1",  4'b1101, 32'h00010000, 32'h00010000, 32'h00000001, 0, 0, 0, 33, 0, 0);
        run_op("divu",     4'b1110, 32'd100, 32'd7, 32'd14, 0, 0, 0, 33, 1, 0);
        run_op("remu",     4'b1111, 32'd100, 32'd7, 32'd2, 0, 0, 0, 33, 0, 0);
        run_op("divu_by0", 4'b1110, 32'd123, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 33, 0, 0);
        run_op("remu_by0", 4'b1111, 32'd123, 32'd0, 32'd123, 0, 0, 0, 33, 0, 0);
        run_op("bp_add",   4'b0010, 32'd10, 32'd20, 32'd30, 0, 0, 0, 1, 0, 5);

        // Reset in the middle of a multiply: no result, outputs cleared at once
        ctrl = 4'b1100; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        check("rstmul_accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("rstmul_busy", {62'd0, out_valid, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("rstmul_cleared", {29'd0, out_valid, res, carry, overflow, zero}, 64'd0);
        check("rstmul_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
